// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the pipelined on-chip memory.
package onchip_mem_pkg;

    // Controller states: INIT sweeps zeros into the array, RUN serves requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

    // Legal range of the accepted-read to readdatavalid delay.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Force a latency parameter into the supported range.
    function automatic int clamp_latency(input int lat);
        int res;
        if (lat < RD_LAT_MIN) begin
            res = RD_LAT_MIN;
        end else if (lat > RD_LAT_MAX) begin
            res = RD_LAT_MAX;
        end else begin
            res = lat;
        end
        return res;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled synchronous single-port RAM. The array itself is never reset;
// only the read output register is, so readdata starts from a known zero.
// Reads outside the populated depth return zero.
module onchip_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_q
);
    localparam int                BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              w_in_range;

    assign w_in_range = ({1'b0, i_addr} < LP_DEPTH);

    // Array write port: update only the enabled byte lanes.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read output register: loads on a read, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_q <= w_in_range ? r_mem[i_addr] : {DATA_W{1'b0}};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Pipelined on-chip memory slave: clear-on-reset sweep, request handshake,
// and a clock-enabled read valid/latency pipeline around onchip_ram_core.
module onchip_memory_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 16384,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done
);
    localparam int                BE_W         = DATA_W / 8;
    localparam int                LP_LAT       = clamp_latency(READ_LATENCY);
    localparam bit                LP_TWO_STAGE = (LP_LAT == RD_LAT_MAX);
    localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST      = ADDR_W'(DEPTH - 1);
    localparam mem_state_e        LP_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              w_wait;
    logic              w_req;
    logic              w_in_range;
    logic              w_acc_wr;
    logic              w_acc_rd;

    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [BE_W-1:0]   w_ram_be;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_q;

    logic              r_vld1;
    logic              r_vld2;
    logic [DATA_W-1:0] r_data2;

    // Handshake: a read with write asserted is a write only; out-of-range
    // writes are accepted but never reach the array.
    assign w_in_range = ({1'b0, address} < LP_DEPTH);
    assign w_req      = chipselect & (read | write) & ~w_wait;
    assign w_acc_wr   = w_req & write & w_in_range;
    assign w_acc_rd   = w_req & read & ~write;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LP_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave INIT after the last word is cleared on an enabled edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (clken && (r_clr_cnt == LP_LAST)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = LP_RST_STATE;
        endcase
    end

    // State outputs: handshake status and RAM port steering.
    always_comb begin
        w_wait      = (r_state == ST_INIT) | ~clken;
        init_done   = (r_state == ST_RUN);
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = address;
        w_ram_be    = byteenable;
        w_ram_wdata = writedata;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = clken;
                w_ram_addr  = r_clr_cnt;
                w_ram_be    = {BE_W{1'b1}};
                w_ram_wdata = {DATA_W{1'b0}};
            end
            ST_RUN: begin
                w_ram_we = w_acc_wr;
                w_ram_re = w_acc_rd;
            end
            default: begin
                w_ram_we = 1'b0;
                w_ram_re = 1'b0;
            end
        endcase
    end

    assign waitrequest = w_wait;

    // Clear-sweep counter: advances one word per enabled cycle while in INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_cnt <= {ADDR_W{1'b0}};
        end else if ((r_state == ST_INIT) && clken) begin
            r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Read valid/data pipeline: advances only on enabled edges, so a stall
    // freezes in-flight reads in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_data2 <= {DATA_W{1'b0}};
        end else if (clken) begin
            r_vld1 <= w_acc_rd;
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_data2 <= w_ram_q;
            end
        end
    end

    // Valid is masked while stalled; it shows on the first enabled cycle.
    assign readdatavalid = (LP_TWO_STAGE ? r_vld2 : r_vld1) & clken;
    assign readdata      = LP_TWO_STAGE ? r_data2 : w_ram_q;

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

endmodule
